// File: rtl/sensor_cond.sv
// sensor_cond: front-end conditioning for the two barrier photo-sensors.
//
// Each channel synchronises its raw line, debounces it and drives a clean
// level to the direction FSMs. A sticky "stuck" detector masks a channel
// that has stayed blocked for STUCK_LIMIT consecutive cycles, so a jammed
// beam cannot hold the downstream FSMs mid-sequence.
//
// Ports:
//   clk         - single clock, all state on rising edge
//   reset       - synchronous, active-high, clears all state
//   a_raw/b_raw - raw asynchronous sensor lines (1 = beam blocked)
//   clear_fault - clears both stuck flags (wins over a simultaneous set)
//   a/b         - clean levels, forced low while the channel is stuck
//   stuck_a/b   - sticky stuck flags

// Per-channel sync + debounce + stuck detector.
//   raw   - asynchronous input line
//   y     - debounced level (unmasked)
//   stuck - sticky fault flag
module sensor_cond_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int STUCK_LIMIT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic clear_fault,
  output logic y,
  output logic stuck
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int SW = $clog2(STUCK_LIMIT);

  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(STUCK_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0]          dcnt;
  logic [SW-1:0]          scnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      y     <= 1'b0;
      dcnt  <= '0;
      scnt  <= '0;
      stuck <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};

      // Debounce: any return of s to y discards the partial count.
      if (s == y) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_LAST) begin
        y    <= s;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end

      // Stuck detector works on the registered y. scnt freezes at
      // STUCK_LIMIT-1 once the flag is set, so it cannot wrap.
      if (clear_fault) begin
        stuck <= 1'b0;
        scnt  <= '0;
      end else if (!y) begin
        scnt <= '0;
      end else if (!stuck && scnt == SCNT_LAST) begin
        stuck <= 1'b1;
      end else if (!stuck) begin
        scnt <= scnt + 1'b1;
      end
    end
  end

endmodule

module sensor_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int STUCK_LIMIT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  input  logic clear_fault,
  output logic a,
  output logic b,
  output logic stuck_a,
  output logic stuck_b
);

  localparam int NUM_LANES = 2;  // lane 0 = A (outer), lane 1 = B (inner)

  logic [NUM_LANES-1:0] raw_vec;
  logic [NUM_LANES-1:0] y_vec;
  logic [NUM_LANES-1:0] stuck_vec;

  assign raw_vec = {b_raw, a_raw};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sensor_cond_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE),
      .STUCK_LIMIT (STUCK_LIMIT)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .raw         (raw_vec[g]),
      .clear_fault (clear_fault),
      .y           (y_vec[g]),
      .stuck       (stuck_vec[g])
    );
  end

  assign a       = y_vec[0] & ~stuck_vec[0];
  assign b       = y_vec[1] & ~stuck_vec[1];
  assign stuck_a = stuck_vec[0];
  assign stuck_b = stuck_vec[1];

endmodule

// File: tb/tb_sensor_cond.sv
// Directed bench for sensor_cond (SYNC_STAGES=2, DEBOUNCE=4, STUCK_LIMIT=16).
// A behavioural model tracks raw-sample history and run lengths; a monitor
// compares all outputs against it every cycle, and the stimulus adds
// hand-computed literal expectations at key cycles.
module tb_sensor_cond;

  localparam int SS = 2;
  localparam int D  = 4;
  localparam int L  = 16;

  logic clk = 1'b0;
  logic reset, a_raw, b_raw, clear_fault;
  logic a, b, stuck_a, stuck_b;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  sensor_cond #(.SYNC_STAGES(SS), .DEBOUNCE(D), .STUCK_LIMIT(L)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_raw       (a_raw),
    .b_raw       (b_raw),
    .clear_fault (clear_fault),
    .a           (a),
    .b           (b),
    .stuck_a     (stuck_a),
    .stuck_b     (stuck_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // One active edge, then return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  // rh: raw values seen at the last SS edges (index 0 oldest) -> the value
  //     the synchroniser presents now.
  // sh: the last D synchronised values; the clean level flips when all of
  //     them disagree with it.
  // run: consecutive edges at which the clean level was high with no clear.
  bit rh [2][SS];
  bit sh [2][D];
  bit my [2];
  bit mstk [2];
  int run [2];

  always @(posedge clk) begin
    bit rawv [2];
    bit s, ypre, flip;
    rawv[0] = a_raw;
    rawv[1] = b_raw;
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        for (int i = 0; i < SS; i++) rh[c][i] = 1'b0;
        for (int i = 0; i < D; i++)  sh[c][i] = 1'b0;
        my[c] = 1'b0; mstk[c] = 1'b0; run[c] = 0;
      end else begin
        ypre = my[c];
        s    = rh[c][0];
        for (int i = 0; i < D - 1; i++) sh[c][i] = sh[c][i+1];
        sh[c][D-1] = s;
        flip = 1'b1;
        for (int i = 0; i < D; i++) if (sh[c][i] == ypre) flip = 1'b0;
        if (clear_fault) begin
          mstk[c] = 1'b0; run[c] = 0;
        end else if (!ypre) begin
          run[c] = 0;
        end else begin
          run[c]++;
          if (run[c] >= L) mstk[c] = 1'b1;
        end
        if (flip) my[c] = ~ypre;
        for (int i = 0; i < SS - 1; i++) rh[c][i] = rh[c][i+1];
        rh[c][SS-1] = rawv[c];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_a",       a,       my[0] & ~mstk[0]);
      chk("mon_b",       b,       my[1] & ~mstk[1]);
      chk("mon_stuck_a", stuck_a, mstk[0]);
      chk("mon_stuck_b", stuck_b, mstk[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int bseq [9];
    bseq = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    reset = 1'b1; a_raw = 1'b0; b_raw = 1'b0; clear_fault = 1'b0;

    // Reset held 3 cycles with random raw inputs.
    for (int i = 0; i < 3; i++) begin
      a_raw = 1'($urandom_range(0, 1));
      b_raw = 1'($urandom_range(0, 1));
      tick();
      mon_en = 1'b1;
      chk("rst_a", a, 1'b0);
      chk("rst_b", b, 1'b0);
      chk("rst_stuck_a", stuck_a, 1'b0);
      chk("rst_stuck_b", stuck_b, 1'b0);
    end
    reset = 1'b0; a_raw = 1'b1; b_raw = 1'b0;
    repeat (5) tick();
    chk("lat_a_edge5", a, 1'b0);
    tick();
    chk("lat_a_edge6", a, 1'b1);
    a_raw = 1'b0;
    repeat (10) tick();
    chk("a_released", a, 1'b0);

    // 3-cycle glitch must be rejected.
    a_raw = 1'b1;
    repeat (3) tick();
    a_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch3_a", a, 1'b0);
    end

    // Exactly DEBOUNCE-cycle pulse -> 4-cycle clean pulse after 6 edges.
    a_raw = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      chk("pulse4_a", a, (t >= 6 && t <= 9));
      if (t == 4) a_raw = 1'b0;
    end

    // Bounce on B: only the final run of four 1s is accepted.
    for (int t = 1; t <= 9; t++) begin
      b_raw = bseq[t-1][0];
      tick();
      chk("bounce_b_early", b, 1'b0);
    end
    b_raw = 1'b1;
    tick();
    chk("bounce_b_edge10", b, 1'b0);
    tick();
    chk("bounce_b_edge11", b, 1'b1);

    // Stuck: y_b rose at edge 11; flag at 16 edges later.
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk("stuck_b_pre", stuck_b, 1'b0);
      chk("stuck_b_pre_b", b, 1'b1);
    end
    tick();
    chk("stuck_b_set", stuck_b, 1'b1);
    chk("stuck_b_masked", b, 1'b0);

    b_raw = 1'b0;
    repeat (10) tick();
    chk("stuck_b_sticky", stuck_b, 1'b1);
    b_raw = 1'b1;
    repeat (10) tick();
    chk("stuck_b_still", stuck_b, 1'b1);
    chk("stuck_b_still_masked", b, 1'b0);

    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clear_stuck_b", stuck_b, 1'b0);
    chk("clear_unmask_b", b, 1'b1);
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk("restuck_pre", stuck_b, 1'b0);
    end
    tick();
    chk("restuck_set", stuck_b, 1'b1);

    // clear_fault held continuously keeps the flag down.
    clear_fault = 1'b1;
    repeat (40) tick();
    chk("clear_held_stuck_b", stuck_b, 1'b0);
    chk("clear_held_b", b, 1'b1);
    clear_fault = 1'b0;
    b_raw = 1'b0;
    repeat (10) tick();
    chk("idle_b", b, 1'b0);
    chk("idle_stuck_b", stuck_b, 1'b0);

    // Entry sequence with 7-cycle spacing (keeps each beam below the limit).
    for (int t = 1; t <= 40; t++) begin
      a_raw = (t <= 14);
      b_raw = (t >= 8 && t <= 21);
      tick();
      chk("entry_a", a, (t >= 6 && t <= 19));
      chk("entry_b", b, (t >= 13 && t <= 26));
      chk("entry_stuck_a", stuck_a, 1'b0);
      chk("entry_stuck_b", stuck_b, 1'b0);
    end

    // Reset mid-operation: A at dcnt=2, B at scnt=10.
    for (int t = 1; t <= 16; t++) begin
      b_raw = 1'b1;
      a_raw = (t >= 13);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_rst_a", a, 1'b0);
    chk("rm_rst_b", b, 1'b0);
    for (int t = 1; t <= 22; t++) begin
      tick();
      chk("rm_a", a, (t >= 6 && t < 22));
      chk("rm_b", b, (t >= 6 && t < 22));
      chk("rm_stuck_a", stuck_a, (t >= 22));
      chk("rm_stuck_b", stuck_b, (t >= 22));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
